// File: rtl/plot_arbiter.sv
// plot_arbiter: round-robin whole-shape arbiter for the single vga_adapter
// plot port, with a built-in full-screen clear engine.
module plot_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int SCR_W   = 160,
    parameter int SCR_H   = 120,
    parameter int TIMEOUT = 4000000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  req,
    input  logic [3:0]  done_in,
    input  logic [31:0] x_in,
    input  logic [27:0] y_in,
    input  logic [11:0] colour_in,
    input  logic [3:0]  plot_in,
    input  logic        clear_req,
    input  logic [2:0]  clear_colour,
    output logic [3:0]  grant,
    output logic [7:0]  x,
    output logic [6:0]  y,
    output logic [2:0]  colour,
    output logic        plot,
    output logic        clear_busy,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        CLEAR = 2'd2
    } state_t;

    localparam logic [21:0] TO_LAST = 22'(TIMEOUT - 1);
    localparam logic [21:0] CNT_MAX = 22'h3F_FFFF;
    localparam logic [7:0]  X_LAST  = 8'(SCR_W - 1);
    localparam logic [6:0]  Y_LAST  = 7'(SCR_H - 1);

    state_t      state_r;
    state_t      state_s;
    logic [1:0]  last_grant_r;
    logic [1:0]  gidx_r;
    logic [21:0] gcnt_r;
    logic        clear_pend_r;
    logic [7:0]  cx_r;
    logic [6:0]  cy_r;
    logic [2:0]  clr_colour_r;

    logic [1:0]  pick_s;
    logic        pick_valid_s;
    logic [1:0]  cand_s;
    logic [7:0]  sel_x_s;
    logic [6:0]  sel_y_s;
    logic [2:0]  sel_c_s;
    logic        sel_plot_s;
    logic        sel_done_s;
    logic        sel_req_s;
    logic        raster_last_s;
    logic        enter_grant_s;
    logic        enter_clear_s;
    logic        exit_grant_s;
    logic        timeout_s;

    // Convert a requester index into its one-hot grant vector.
    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        logic [3:0] v;
        v = 4'b0001 << idx;
        return v;
    endfunction

    // Round-robin search starting one past the last served requester.
    always_comb begin
        pick_s       = 2'd0;
        pick_valid_s = 1'b0;
        cand_s       = 2'd0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand_s = last_grant_r + 2'(i);
            if (!pick_valid_s && req[cand_s]) begin
                pick_s       = cand_s;
                pick_valid_s = 1'b1;
            end else begin
                pick_valid_s = pick_valid_s;
            end
        end
    end

    // Select the granted requester's pixel lane and handshake bits.
    always_comb begin
        sel_done_s = done_in[gidx_r];
        sel_req_s  = req[gidx_r];
        sel_plot_s = plot_in[gidx_r];
        case (gidx_r)
            2'd0: begin
                sel_x_s = x_in[7:0];
                sel_y_s = y_in[6:0];
                sel_c_s = colour_in[2:0];
            end
            2'd1: begin
                sel_x_s = x_in[15:8];
                sel_y_s = y_in[13:7];
                sel_c_s = colour_in[5:3];
            end
            2'd2: begin
                sel_x_s = x_in[23:16];
                sel_y_s = y_in[20:14];
                sel_c_s = colour_in[8:6];
            end
            2'd3: begin
                sel_x_s = x_in[31:24];
                sel_y_s = y_in[27:21];
                sel_c_s = colour_in[11:9];
            end
            default: begin
                sel_x_s = 8'd0;
                sel_y_s = 7'd0;
                sel_c_s = 3'd0;
            end
        endcase
    end

    assign raster_last_s = (cx_r == X_LAST) && (cy_r == Y_LAST);

    // Next-state logic; clear beats requests, done/req-drop beat timeout.
    always_comb begin
        state_s       = state_r;
        enter_grant_s = 1'b0;
        enter_clear_s = 1'b0;
        exit_grant_s  = 1'b0;
        timeout_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (clear_pend_r || clear_req) begin
                    state_s       = CLEAR;
                    enter_clear_s = 1'b1;
                end else if (pick_valid_s) begin
                    state_s       = GRANT;
                    enter_grant_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            GRANT: begin
                if (sel_done_s || !sel_req_s) begin
                    state_s      = IDLE;
                    exit_grant_s = 1'b1;
                end else if (gcnt_r == TO_LAST) begin
                    state_s      = IDLE;
                    exit_grant_s = 1'b1;
                    timeout_s    = 1'b1;
                end else begin
                    state_s = GRANT;
                end
            end
            CLEAR: begin
                if (raster_last_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = CLEAR;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Clear request latch: armed outside CLEAR, consumed on entry to CLEAR.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            clear_pend_r <= 1'b0;
        end else if (enter_clear_s) begin
            clear_pend_r <= 1'b0;
        end else if (state_r != CLEAR && clear_req) begin
            clear_pend_r <= 1'b1;
        end
    end

    // Grant bookkeeping, raster counters and the registered plot-port outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            grant        <= 4'd0;
            gidx_r       <= 2'd0;
            last_grant_r <= 2'd3;
            gcnt_r       <= 22'd0;
            cx_r         <= 8'd0;
            cy_r         <= 7'd0;
            clr_colour_r <= 3'd0;
            x            <= 8'd0;
            y            <= 7'd0;
            colour       <= 3'd0;
            plot         <= 1'b0;
            clear_busy   <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            timeout_err <= timeout_s;
            case (state_r)
                IDLE: begin
                    plot <= 1'b0;
                    if (enter_clear_s) begin
                        // First raster pixel goes out on the entry edge so that
                        // plot and clear_busy line up cycle for cycle.
                        cx_r         <= 8'd0;
                        cy_r         <= 7'd0;
                        clr_colour_r <= clear_colour;
                        x            <= 8'd0;
                        y            <= 7'd0;
                        colour       <= clear_colour;
                        plot         <= 1'b1;
                        clear_busy   <= 1'b1;
                    end else if (enter_grant_s) begin
                        grant  <= onehot4(pick_s);
                        gidx_r <= pick_s;
                        gcnt_r <= 22'd0;
                    end
                end
                GRANT: begin
                    if (exit_grant_s) begin
                        grant        <= 4'd0;
                        last_grant_r <= gidx_r;
                        plot         <= 1'b0;
                    end else begin
                        plot <= sel_plot_s;
                        if (sel_plot_s) begin
                            x      <= sel_x_s;
                            y      <= sel_y_s;
                            colour <= sel_c_s;
                        end
                        if (gcnt_r != CNT_MAX) begin
                            gcnt_r <= gcnt_r + 22'd1;
                        end
                    end
                end
                CLEAR: begin
                    if (raster_last_s) begin
                        plot       <= 1'b0;
                        clear_busy <= 1'b0;
                    end else if (cx_r == X_LAST) begin
                        cx_r   <= 8'd0;
                        cy_r   <= cy_r + 7'd1;
                        x      <= 8'd0;
                        y      <= cy_r + 7'd1;
                        colour <= clr_colour_r;
                        plot   <= 1'b1;
                    end else begin
                        cx_r   <= cx_r + 8'd1;
                        x      <= cx_r + 8'd1;
                        y      <= cy_r;
                        colour <= clr_colour_r;
                        plot   <= 1'b1;
                    end
                end
                default: begin
                    grant      <= 4'd0;
                    plot       <= 1'b0;
                    clear_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_plot_arbiter.sv
// Directed self-checking bench for plot_arbiter (TIMEOUT shortened to 16).
module tb_plot_arbiter;

    logic        clk;
    logic        reset_n;
    logic [3:0]  req;
    logic [3:0]  done_in;
    logic [31:0] x_in;
    logic [27:0] y_in;
    logic [11:0] colour_in;
    logic [3:0]  plot_in;
    logic        clear_req;
    logic [2:0]  clear_colour;
    logic [3:0]  grant;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;
    logic        plot;
    logic        clear_busy;
    logic        timeout_err;

    int n_checks = 0;
    int n_errors = 0;

    plot_arbiter #(
        .NUM_REQ (4),
        .SCR_W   (160),
        .SCR_H   (120),
        .TIMEOUT (16)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req          (req),
        .done_in      (done_in),
        .x_in         (x_in),
        .y_in         (y_in),
        .colour_in    (colour_in),
        .plot_in      (plot_in),
        .clear_req    (clear_req),
        .clear_colour (clear_colour),
        .grant        (grant),
        .x            (x),
        .y            (y),
        .colour       (colour),
        .plot         (plot),
        .clear_busy   (clear_busy),
        .timeout_err  (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; sample point is 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        int bad;
        logic [7:0] ex;
        logic [6:0] ey;
        logic [7:0] lx;
        logic [6:0] ly;

        reset_n = 1'b0; req = 4'hF; done_in = 4'h0; x_in = 32'd0; y_in = 28'd0;
        colour_in = 12'd0; plot_in = 4'h0; clear_req = 1'b0; clear_colour = 3'd0;

        // 1: reset
        tick(); tick();
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_plot", 32'(plot), 32'h0);
        chk("rst_xyc", {13'd0, x, y, colour}, 32'h0);
        chk("rst_busy_to", {30'd0, clear_busy, timeout_err}, 32'h0);
        reset_n = 1'b1;
        tick();
        chk("rst_first_grant", 32'(grant), 32'h1);
        req = 4'h0;
        tick();
        chk("rst_drop_grant", 32'(grant), 32'h0);

        // 2: round-robin between requesters 1 and 3
        req = 4'b1010;
        tick();
        chk("rr_g1", 32'(grant), 32'b0010);
        done_in = 4'b0010;
        tick();
        chk("rr_gap1", 32'(grant), 32'h0);
        chk("rr_no_timeout", 32'(timeout_err), 32'h0);
        done_in = 4'h0;
        tick();
        chk("rr_g3", 32'(grant), 32'b1000);
        done_in = 4'b1000;
        tick();
        chk("rr_gap2", 32'(grant), 32'h0);
        done_in = 4'h0;
        tick();
        chk("rr_g1_again", 32'(grant), 32'b0010);
        done_in = 4'b0010;
        tick();
        chk("rr_gap3", 32'(grant), 32'h0);
        done_in = 4'h0; req = 4'h0;
        tick();
        chk("rr_idle", 32'(grant), 32'h0);

        // 3: pass-through for requester 2, requester 0 strobe blocked
        req = 4'b0100;
        tick();
        chk("pt_grant", 32'(grant), 32'b0100);
        x_in = {8'd0, 8'd79, 8'd0, 8'd5};
        y_in = {7'd0, 7'd63, 7'd0, 7'd9};
        colour_in = {3'd0, 3'b100, 3'd0, 3'b010};
        plot_in = 4'b0101;
        tick();
        chk("pt_x", 32'(x), 32'd79);
        chk("pt_y", 32'(y), 32'd63);
        chk("pt_colour", 32'(colour), 32'd4);
        chk("pt_plot", 32'(plot), 32'h1);
        plot_in = 4'b0001;
        tick();
        chk("pt_blocked_plot", 32'(plot), 32'h0);
        chk("pt_hold_x", 32'(x), 32'd79);
        done_in = 4'b0100; plot_in = 4'b0100;
        tick();
        chk("pt_drop_plot", 32'(plot), 32'h0);
        chk("pt_drop_grant", 32'(grant), 32'h0);
        done_in = 4'h0; req = 4'h0; plot_in = 4'h0;
        tick();

        // 4: full-screen clear in colour 0 (output colour was 4 before)
        clear_colour = 3'b000; clear_req = 1'b1;
        tick();
        clear_req = 1'b0; clear_colour = 3'b111;
        chk("clr_first_xy", {17'd0, x, y}, {17'd0, 8'd0, 7'd0});
        chk("clr_busy_on", 32'(clear_busy), 32'h1);
        n = 0; bad = 0; ex = 8'd0; ey = 7'd0; lx = 8'd0; ly = 7'd0;
        while (plot === 1'b1 && n < 20000) begin
            if (x !== ex || y !== ey || colour !== 3'b000 || clear_busy !== 1'b1) bad++;
            lx = x; ly = y;
            if (ex == 8'd159) begin
                ex = 8'd0; ey = ey + 7'd1;
            end else begin
                ex = ex + 8'd1;
            end
            n++;
            tick();
        end
        chk("clr_count", 32'(n), 32'd19200);
        chk("clr_raster_bad", 32'(bad), 32'd0);
        chk("clr_last_xy", {17'd0, lx, ly}, {17'd0, 8'd159, 7'd119});
        chk("clr_busy_off", 32'(clear_busy), 32'h0);
        tick();
        chk("clr_idle_plot", 32'(plot), 32'h0);

        // 5: clear requested during a grant is served before the pending req
        req = 4'b0001;
        tick();
        chk("cg_grant0", 32'(grant), 32'b0001);
        req = 4'b0011; clear_req = 1'b1;
        tick();
        chk("cg_grant_held", 32'(grant), 32'b0001);
        clear_req = 1'b0; done_in = 4'b0001;
        tick();
        chk("cg_grant_drop", 32'(grant), 32'h0);
        done_in = 4'h0; req = 4'b0010;
        tick();
        chk("cg_clear_first", {28'd0, grant, clear_busy}, {28'd0, 4'h0, 1'b1});
        n = 0;
        while (clear_busy === 1'b1 && n < 20000) begin
            if (grant !== 4'h0) bad++;
            n++;
            tick();
        end
        chk("cg_clear_len", 32'(n), 32'd19200);
        chk("cg_no_grant_in_clear", 32'(bad), 32'd0);
        chk("cg_gap", 32'(grant), 32'h0);
        tick();
        chk("cg_grant1", 32'(grant), 32'b0010);
        req = 4'h0;
        tick();

        // 6: timeout on requester 3 after 16 grant cycles
        req = 4'b1000;
        tick();
        chk("to_grant3", 32'(grant), 32'b1000);
        n = 0; bad = 0;
        while (grant === 4'b1000 && n < 100) begin
            if (timeout_err !== 1'b0) bad++;
            n++;
            tick();
        end
        chk("to_cycles", 32'(n), 32'd16);
        chk("to_early_err", 32'(bad), 32'd0);
        chk("to_err_pulse", 32'(timeout_err), 32'h1);
        chk("to_grant_drop", 32'(grant), 32'h0);
        req = 4'h0;
        tick();
        chk("to_err_clear", 32'(timeout_err), 32'h0);
        chk("to_idle", 32'(grant), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
